// File: rtl/pp_mult_pkg.sv
// Shared definitions for the shift-add multiplier: the controller state
// encoding and the width helper used to size the row index.
package pp_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bits needed to index 0..value-1, never less than one.
  function automatic int clog2w(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) begin
        r = i + 1;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pp_row_gen.sv
// One partial-product row: the multiplicand widened to the product width
// and gated by a single multiplier bit.
module pp_row_gen #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]   a,
  input  logic               b_bit,
  input  logic               is_signed,
  output logic [2*WIDTH-1:0] row
);

  logic [2*WIDTH-1:0] ext_s;

  // Widen the multiplicand, then gate it with the multiplier bit.
  always_comb begin
    ext_s = '0;
    if (is_signed) begin
      ext_s = {{WIDTH{a[WIDTH-1]}}, a};
    end else begin
      ext_s = {{WIDTH{1'b0}}, a};
    end
    row = ext_s & {(2*WIDTH){b_bit}};
  end

endmodule

// File: rtl/pp_shift_add_multiplier.sv
// Sequential shift-add multiplier: one partial-product row per cycle, with
// the sign row subtracted in two's-complement mode (Baugh-Wooley style).
module pp_shift_add_multiplier
  import pp_mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_a,
  input  logic [WIDTH-1:0]            in_b,
  input  logic                        in_signed,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [2*WIDTH-1:0]          out_p,
  output logic [clog2w(WIDTH)-1:0]    row_idx
);

  localparam int IW = clog2w(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  state_e               state_r;
  logic [WIDTH-1:0]     a_r;
  logic [WIDTH-1:0]     b_r;
  logic                 sgn_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [IW-1:0]        idx_r;
  logic [2*WIDTH-1:0]   row_s;
  logic [2*WIDTH-1:0]   row_sh_s;
  logic [2*WIDTH-1:0]   acc_next_s;

  pp_row_gen #(.WIDTH(WIDTH)) u_row_gen (
    .a         (a_r),
    .b_bit     (b_r[idx_r]),
    .is_signed (sgn_r),
    .row       (row_s)
  );

  assign row_idx = idx_r;

  // Accumulate the shifted row; the multiplier sign bit carries weight -2^(W-1).
  always_comb begin
    row_sh_s   = row_s << idx_r;
    acc_next_s = '0;
    if (sgn_r && (idx_r == LAST_IDX)) begin
      acc_next_s = acc_r - row_sh_s;
    end else begin
      acc_next_s = acc_r + row_sh_s;
    end
  end

  // Controller and all registered outputs; idx is parked at 0 outside BUSY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      a_r       <= '0;
      b_r       <= '0;
      sgn_r     <= 1'b0;
      acc_r     <= '0;
      idx_r     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_p     <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            a_r      <= in_a;
            b_r      <= in_b;
            sgn_r    <= in_signed;
            acc_r    <= '0;
            idx_r    <= '0;
            in_ready <= 1'b0;
            state_r  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          acc_r <= acc_next_s;
          if (idx_r == LAST_IDX) begin
            idx_r     <= '0;
            out_valid <= 1'b1;
            out_p     <= acc_next_s;
            state_r   <= ST_DONE;
          end else begin
            idx_r <= idx_r + IW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_p     <= '0;
            in_ready  <= 1'b1;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          idx_r     <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_p     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pp_shift_add_multiplier.sv
// Bench for pp_shift_add_multiplier: directed table at WIDTH=4, corner
// sequences (backpressure, mid-operation reset), random run at WIDTH=8.
module tb_pp_shift_add_multiplier;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       iv4, ir4, s4, ov4, or4;
  logic [3:0] a4, b4;
  logic [7:0] p4;
  logic [1:0] ri4;

  logic        iv8, ir8, s8, ov8, or8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic [2:0]  ri8;

  pp_shift_add_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .in_a(a4),
    .in_b(b4), .in_signed(s4), .out_valid(ov4), .out_ready(or4),
    .out_p(p4), .row_idx(ri4)
  );

  pp_shift_add_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_a(a8),
    .in_b(b8), .in_signed(s8), .out_valid(ov8), .out_ready(or8),
    .out_p(p8), .row_idx(ri8)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       s;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Issue one WIDTH=4 operation and wait for out_valid; returns product and latency.
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s,
                     output logic [7:0] p, output int lat);
    int n;
    n = 0;
    while (!ir4 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    iv4 = 1'b1; a4 = a; b4 = b; s4 = s;
    @(posedge clk); #1;
    iv4 = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (ov4) break;
    end
    p = p4;
  endtask

  task automatic hs4();
    or4 = 1'b1;
    @(posedge clk); #1;
    or4 = 1'b0;
  endtask

  initial begin
    logic [7:0] p;
    int lat;
    int n;
    logic seen;

    vecs[0]  = '{4'hF, 4'hF, 1'b0, 8'hE1};
    vecs[1]  = '{4'h8, 4'h8, 1'b1, 8'h40};
    vecs[2]  = '{4'h8, 4'h7, 1'b1, 8'hC8};
    vecs[3]  = '{4'h5, 4'hD, 1'b1, 8'hF1};
    vecs[4]  = '{4'h3, 4'h4, 1'b0, 8'h0C};
    vecs[5]  = '{4'h0, 4'h9, 1'b0, 8'h00};
    vecs[6]  = '{4'h8, 4'h8, 1'b0, 8'h40};
    vecs[7]  = '{4'hF, 4'hF, 1'b1, 8'h01};
    vecs[8]  = '{4'h7, 4'h7, 1'b1, 8'h31};
    vecs[9]  = '{4'hF, 4'h1, 1'b1, 8'hFF};
    vecs[10] = '{4'hF, 4'h1, 1'b0, 8'h0F};
    vecs[11] = '{4'h0, 4'h8, 1'b1, 8'h00};
    vecs[12] = '{4'h7, 4'h8, 1'b1, 8'hC8};

    rst_n = 1'b0;
    iv4 = 1'b0; a4 = '0; b4 = '0; s4 = 1'b0; or4 = 1'b0;
    iv8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0; or8 = 1'b0;
    #12;
    chk("rst_in_ready", 32'(ir4), 32'd1);
    chk("rst_out_valid", 32'(ov4), 32'd0);
    chk("rst_out_p", 32'(p4), 32'd0);
    chk("rst_row_idx", 32'(ri4), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      op4(vecs[i].a, vecs[i].b, vecs[i].s, p, lat);
      chk($sformatf("lat[%0d]", i), 32'(lat), 32'd4);
      chk($sformatf("prod[%0d]", i), 32'(p), 32'(vecs[i].exp));
      chk($sformatf("busy_idx0[%0d]", i), 32'(ri4), 32'd0);
      hs4();
      chk($sformatf("post_valid[%0d]", i), 32'(ov4), 32'd0);
      chk($sformatf("post_p[%0d]", i), 32'(p4), 32'd0);
      chk($sformatf("post_ready[%0d]", i), 32'(ir4), 32'd1);
    end

    // Backpressure: result held in DONE while in_valid pulses are ignored.
    op4(4'h3, 4'h5, 1'b0, p, lat);
    chk("bp_prod", 32'(p), 32'h0F);
    for (int i = 0; i < 10; i++) begin
      iv4 = i[0]; a4 = 4'(i); b4 = 4'hF;
      @(posedge clk); #1;
      chk("bp_hold_p", 32'(p4), 32'h0F);
      chk("bp_in_ready", 32'(ir4), 32'd0);
      chk("bp_out_valid", 32'(ov4), 32'd1);
    end
    iv4 = 1'b0;
    hs4();
    chk("bp_release_valid", 32'(ov4), 32'd0);
    chk("bp_release_ready", 32'(ir4), 32'd1);

    // Reset in the middle of BUSY.
    iv4 = 1'b1; a4 = 4'h6; b4 = 4'h7; s4 = 1'b0;
    @(posedge clk); #1;
    iv4 = 1'b0;
    n = 0;
    while (ri4 != 2'd2 && n < 10) begin
      @(posedge clk); #1; n++;
    end
    chk("rst_reach_idx2", 32'(ri4), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_row_idx", 32'(ri4), 32'd0);
    chk("mid_rst_out_valid", 32'(ov4), 32'd0);
    chk("mid_rst_out_p", 32'(p4), 32'd0);
    chk("mid_rst_in_ready", 32'(ir4), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (ov4) seen = 1'b1;
    end
    chk("no_stale_valid", 32'(seen), 32'd0);
    op4(4'h3, 4'h4, 1'b0, p, lat);
    chk("after_rst_lat", 32'(lat), 32'd4);
    chk("after_rst_prod", 32'(p), 32'h0C);
    hs4();

    // WIDTH=8 random back-to-back run with random consumer stalls.
    begin
      int prev_acc;
      int acc_cyc;
      int ia, ib, prod;
      logic [15:0] exp16;
      logic hs;
      logic got;
      prev_acc = -1;
      for (int k = 0; k < 1000; k++) begin
        a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
        if ((k % 50) == 0) begin a8 = 8'h80; b8 = 8'h80; end
        if (s8) begin ia = $signed(a8); ib = $signed(b8); end
        else begin ia = int'(a8); ib = int'(b8); end
        prod = ia * ib;
        exp16 = prod[15:0];
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        n = 0;
        while (!ir8 && n < 100) begin
          @(posedge clk); #1; n++;
        end
        iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        acc_cyc = cyc;
        if (prev_acc >= 0) chk("w8_interval_ge10", 32'(acc_cyc - prev_acc >= 10), 32'd1);
        prev_acc = acc_cyc;
        or8 = 1'($urandom);
        got = 1'b0;
        n = 0;
        hs = 1'b0;
        while (!hs && n < 100) begin
          hs = ov8 && or8;
          if (ov8 && !got) begin
            chk("w8_prod", 32'(p8), 32'(exp16));
            got = 1'b1;
          end
          @(posedge clk); #1;
          n++;
          if (!hs) or8 = 1'($urandom);
        end
        or8 = 1'b0;
        if (!hs) chk("w8_handshake_timeout", 32'd0, 32'd1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
